// File: rtl/xadc_drp_scheduler_if.sv
// ---------------------------------------------------------------------------
// xadc_drp_scheduler_if
//   Bundles the XADC-facing DRP/EOC signals and the tagged sample stream
//   that the scheduler produces for the downstream averagers.
//
//   Signals
//     eoc          XADC end-of-conversion level
//     drdy         XADC DRP data ready
//     do_in        XADC DRP read data (16 bits)
//     den          DRP enable pulse
//     daddr        DRP address (7 bits)
//     dwe          DRP write enable (always 0, reads only)
//     di           DRP write data (always 0)
//     sample_data  captured DRP word
//     sample_ch    channel index of sample_data
//     sample_valid one-cycle strobe qualifying sample_data/sample_ch
//
//   Modports
//     master  the scheduler side (drives DRP requests and the sample stream)
//     slave   the XADC / consumer side
// ---------------------------------------------------------------------------
interface xadc_drp_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic          eoc;
    logic          drdy;
    logic [15:0]   do_in;
    logic          den;
    logic [6:0]    daddr;
    logic          dwe;
    logic [15:0]   di;
    logic [15:0]   sample_data;
    logic [CW-1:0] sample_ch;
    logic          sample_valid;

    modport master (
        input  eoc, drdy, do_in,
        output den, daddr, dwe, di, sample_data, sample_ch, sample_valid
    );

    modport slave (
        output eoc, drdy, do_in,
        input  den, daddr, dwe, di, sample_data, sample_ch, sample_valid
    );
endinterface

// File: rtl/xadc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// xadc_drp_scheduler
//   Lets one XADC serve several auxiliary analog inputs. Every rising edge of
//   eoc triggers one DRP read of the next enabled channel in round-robin
//   order. The read word leaves as a one-cycle tagged strobe on the sample
//   stream. A read that never sees drdy is abandoned after TIMEOUT cycles.
//
//   Parameters
//     NUM_CH    number of scheduled channels (1..8)
//     CH_ADDRS  packed 7-bit DRP addresses, channel i at [7*i +: 7]
//     TIMEOUT   cycles spent waiting for drdy before giving up
//
//   Ports
//     clk          DRP clock, everything on the rising edge
//     reset        synchronous, active-high
//     bus          DRP request/response and sample stream (master side)
//     ch_enable    per-channel schedule mask, looked at only when picking
//     err_clr      one-cycle pulse clearing timeout_err and overrun
//     timeout_err  sticky: a read was abandoned for lack of drdy
//     overrun      sticky: an eoc edge was dropped because one was already queued
// ---------------------------------------------------------------------------
module xadc_drp_scheduler #(
    parameter int                  NUM_CH   = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDRS = {7'h16, 7'h1E, 7'h17, 7'h1F},
    parameter int                  TIMEOUT  = 63
) (
    input  logic                        clk,
    input  logic                        reset,
    xadc_drp_scheduler_if.master        bus,
    input  logic [NUM_CH-1:0]           ch_enable,
    input  logic                        err_clr,
    output logic                        timeout_err,
    output logic                        overrun
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE
    } state_t;

    state_t        state_q, state_d;
    logic          eoc_q;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] counter_q, counter_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] last_q, last_d;
    logic [15:0]   data_q, data_d;
    logic [CW-1:0] sample_ch_q, sample_ch_d;

    logic          eoc_edge;
    logic          sel_found;
    logic [CW-1:0] sel_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            eoc_q       <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            counter_q   <= '0;
            daddr_q     <= '0;
            ch_q        <= '0;
            // Pointing at the last channel makes channel 0 the first pick.
            last_q      <= CW'(NUM_CH - 1);
            data_q      <= '0;
            sample_ch_q <= '0;
        end else begin
            state_q     <= state_d;
            eoc_q       <= bus.eoc;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            counter_q   <= counter_d;
            daddr_q     <= daddr_d;
            ch_q        <= ch_d;
            last_q      <= last_d;
            data_q      <= data_d;
            sample_ch_q <= sample_ch_d;
        end
    end

    // Round-robin pick: first enabled channel after the last one served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!sel_found && ch_enable[(int'(last_q) + i) % NUM_CH]) begin
                sel_found = 1'b1;
                sel_idx   = CW'((int'(last_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        eoc_edge    = bus.eoc & ~eoc_q;
        state_d     = state_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        counter_d   = counter_q;
        daddr_d     = daddr_q;
        ch_d        = ch_q;
        last_d      = last_q;
        data_d      = data_q;
        sample_ch_d = sample_ch_q;

        // Clear first so that a set later in this cycle takes priority.
        if (err_clr) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end

        // While a read is in flight only one further event can be queued.
        if (state_q != S_IDLE && eoc_edge) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (eoc_edge || pending_q) begin
                    // Serving a queued event while a new edge arrives keeps
                    // the new edge queued. With nothing enabled the event is
                    // simply consumed.
                    pending_d = pending_q && eoc_edge;
                    if (sel_found) begin
                        state_d = S_ISSUE;
                        daddr_d = CH_ADDRS[7*int'(sel_idx) +: 7];
                        ch_d    = sel_idx;
                    end
                end
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                counter_d = '0;
            end
            S_WAIT: begin
                if (bus.drdy) begin
                    data_d      = bus.do_in;
                    sample_ch_d = ch_q;
                    state_d     = S_STORE;
                end else if (counter_q == TW'(TIMEOUT - 1)) begin
                    // Give up, but still move the round-robin past this
                    // channel so a dead input cannot starve the others.
                    timeout_d = 1'b1;
                    last_d    = ch_q;
                    state_d   = S_IDLE;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            S_STORE: begin
                last_d  = ch_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.den          = (state_q == S_ISSUE);
    assign bus.daddr        = daddr_q;
    assign bus.dwe          = 1'b0;
    assign bus.di           = '0;
    assign bus.sample_data  = data_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_valid = (state_q == S_STORE);
    assign timeout_err      = timeout_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xadc_drp_scheduler
//   Directed scenarios for the XADC DRP scheduler. Inputs change and outputs
//   are observed on the falling clock edge, so each negedge marks one cycle.
// ---------------------------------------------------------------------------
module tb_xadc_drp_scheduler;

    // Address map laid out so that channels 0..3 map to 1F,1E,17,16.
    localparam logic [27:0] ADDRS = {7'h16, 7'h17, 7'h1E, 7'h1F};

    logic       clk;
    logic       reset;
    logic [3:0] ch_enable;
    logic       err_clr;
    logic       timeout_err;
    logic       overrun;

    int checks;
    int failures;

    logic [6:0] exp_addr [4];

    xadc_drp_scheduler_if #(.NUM_CH(4)) bus ();

    xadc_drp_scheduler #(
        .NUM_CH  (4),
        .CH_ADDRS(ADDRS),
        .TIMEOUT (63)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ch_enable  (ch_enable),
        .err_clr    (err_clr),
        .timeout_err(timeout_err),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One complete read: edge at N, den at N+1, drdy at N+4, strobe at N+5.
    task automatic run_read(input int ch, input logic [15:0] data);
        @(negedge clk);
        bus.eoc = 1'b1;
        checks++;
        if (bus.den !== 1'b0) begin
            failures++;
            $display("[TB] FAIL den_before_issue ch%0d: got %b expected 0", ch, bus.den);
        end
        @(negedge clk);
        bus.eoc = 1'b0;
        checks++;
        if (bus.den !== 1'b1) begin
            failures++;
            $display("[TB] FAIL den_issue ch%0d: got %b expected 1", ch, bus.den);
        end
        checks++;
        if (bus.daddr !== exp_addr[ch]) begin
            failures++;
            $display("[TB] FAIL daddr ch%0d: got %h expected %h", ch, bus.daddr, exp_addr[ch]);
        end
        @(negedge clk);
        checks++;
        if (bus.den !== 1'b0) begin
            failures++;
            $display("[TB] FAIL den_one_cycle ch%0d: got %b expected 0", ch, bus.den);
        end
        @(negedge clk);
        @(negedge clk);
        bus.drdy  = 1'b1;
        bus.do_in = data;
        checks++;
        if (bus.sample_valid !== 1'b0 || bus.daddr !== exp_addr[ch]) begin
            failures++;
            $display("[TB] FAIL wait_outputs ch%0d: got valid=%b daddr=%h expected valid=0 daddr=%h",
                     ch, bus.sample_valid, bus.daddr, exp_addr[ch]);
        end
        @(negedge clk);
        bus.drdy  = 1'b0;
        bus.do_in = 16'h0000;
        checks++;
        if (bus.sample_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sample_valid ch%0d: got %b expected 1", ch, bus.sample_valid);
        end
        checks++;
        if (bus.sample_data !== data || bus.sample_ch !== 2'(ch)) begin
            failures++;
            $display("[TB] FAIL sample ch%0d: got data=%h ch=%0d expected data=%h ch=%0d",
                     ch, bus.sample_data, bus.sample_ch, data, ch);
        end
        @(negedge clk);
        checks++;
        if (bus.sample_valid !== 1'b0 || bus.sample_data !== data) begin
            failures++;
            $display("[TB] FAIL sample_hold ch%0d: got valid=%b data=%h expected valid=0 data=%h",
                     ch, bus.sample_valid, bus.sample_data, data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.den, bus.daddr, bus.dwe, bus.di, bus.sample_data, bus.sample_ch,
             bus.sample_valid, timeout_err, overrun} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got den=%b daddr=%h data=%h ch=%0d valid=%b to=%b ov=%b expected all 0",
                     bus.den, bus.daddr, bus.sample_data, bus.sample_ch, bus.sample_valid,
                     timeout_err, overrun);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        ch_enable = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_read(i % 4, 16'h1000 + 16'(i));
        end
    endtask

    task automatic test_sparse_mask();
        ch_enable = 4'b1010;
        run_read(1, 16'h0101);
        run_read(3, 16'h0303);
        run_read(1, 16'h1111);
        run_read(3, 16'h3333);
    endtask

    task automatic test_all_disabled();
        int bad;
        bad = 0;
        ch_enable = 4'b0000;
        @(negedge clk);
        bus.eoc = 1'b1;
        @(negedge clk);
        bus.eoc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.den !== 1'b0 || bus.sample_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL disabled_no_activity: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_latency();
        ch_enable = 4'b1111;
        run_read(0, 16'hABCD);
    endtask

    task automatic test_timeout();
        int bad;
        ch_enable = 4'b1111;
        @(negedge clk);
        bus.eoc = 1'b1;
        @(negedge clk);
        bus.eoc = 1'b0;
        checks++;
        if (bus.den !== 1'b1 || bus.daddr !== exp_addr[1]) begin
            failures++;
            $display("[TB] FAIL timeout_issue: got den=%b daddr=%h expected den=1 daddr=%h",
                     bus.den, bus.daddr, exp_addr[1]);
        end
        bad = 0;
        for (int k = 0; k < 63; k++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || bus.sample_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL timeout_early: got %0d bad cycles expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || bus.sample_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_set: got to=%b valid=%b expected to=1 valid=0",
                     timeout_err, bus.sample_valid);
        end
        run_read(2, 16'h1234);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_clear: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        ch_enable = 4'b1111;
        @(negedge clk);
        bus.eoc = 1'b1;
        @(negedge clk);
        bus.eoc = 1'b0;
        checks++;
        if (bus.den !== 1'b1 || bus.daddr !== exp_addr[3]) begin
            failures++;
            $display("[TB] FAIL b2b_first_issue: got den=%b daddr=%h expected den=1 daddr=%h",
                     bus.den, bus.daddr, exp_addr[3]);
        end
        @(negedge clk);
        bus.eoc = 1'b1;
        @(negedge clk);
        bus.eoc = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_first_queue: got %b expected 0", overrun);
        end
        @(negedge clk);
        bus.eoc = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        bus.eoc   = 1'b0;
        err_clr   = 1'b0;
        bus.drdy  = 1'b1;
        bus.do_in = 16'hC0DE;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun_set_over_clear: got %b expected 1", overrun);
        end
        @(negedge clk);
        bus.drdy  = 1'b0;
        bus.do_in = 16'h0000;
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 2'd3 || bus.sample_data !== 16'hC0DE) begin
            failures++;
            $display("[TB] FAIL b2b_first_sample: got valid=%b ch=%0d data=%h expected valid=1 ch=3 data=c0de",
                     bus.sample_valid, bus.sample_ch, bus.sample_data);
        end
        @(negedge clk);
        checks++;
        if (bus.den !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle_gap: got den=%b expected 0", bus.den);
        end
        @(negedge clk);
        checks++;
        if (bus.den !== 1'b1 || bus.daddr !== exp_addr[0]) begin
            failures++;
            $display("[TB] FAIL b2b_pending_issue: got den=%b daddr=%h expected den=1 daddr=%h",
                     bus.den, bus.daddr, exp_addr[0]);
        end
        @(negedge clk);
        @(negedge clk);
        bus.drdy  = 1'b1;
        bus.do_in = 16'h7777;
        @(negedge clk);
        bus.drdy  = 1'b0;
        bus.do_in = 16'h0000;
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 2'd0 || bus.sample_data !== 16'h7777) begin
            failures++;
            $display("[TB] FAIL b2b_second_sample: got valid=%b ch=%0d data=%h expected valid=1 ch=0 data=7777",
                     bus.sample_valid, bus.sample_ch, bus.sample_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        ch_enable = 4'b1111;
        @(negedge clk);
        bus.eoc = 1'b1;
        @(negedge clk);
        bus.eoc = 1'b0;
        checks++;
        if (bus.den !== 1'b1 || bus.daddr !== exp_addr[1]) begin
            failures++;
            $display("[TB] FAIL midreset_issue: got den=%b daddr=%h expected den=1 daddr=%h",
                     bus.den, bus.daddr, exp_addr[1]);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.drdy  = 1'b1;
        bus.do_in = 16'hBEEF;
        checks++;
        if ({bus.den, bus.daddr, bus.sample_data, bus.sample_ch, bus.sample_valid,
             timeout_err, overrun} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got den=%b daddr=%h data=%h ch=%0d valid=%b to=%b ov=%b expected all 0",
                     bus.den, bus.daddr, bus.sample_data, bus.sample_ch, bus.sample_valid,
                     timeout_err, overrun);
        end
        @(negedge clk);
        bus.drdy  = 1'b0;
        bus.do_in = 16'h0000;
        checks++;
        if (bus.sample_valid !== 1'b0 || bus.sample_data !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL midreset_late_drdy: got valid=%b data=%h expected valid=0 data=0000",
                     bus.sample_valid, bus.sample_data);
        end
        run_read(0, 16'h5A5A);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_addr[0] = 7'h1F;
        exp_addr[1] = 7'h1E;
        exp_addr[2] = 7'h17;
        exp_addr[3] = 7'h16;
        reset       = 1'b1;
        ch_enable   = 4'b0000;
        err_clr     = 1'b0;
        bus.eoc     = 1'b0;
        bus.drdy    = 1'b0;
        bus.do_in   = 16'h0000;

        test_reset();
        test_round_robin();
        test_sparse_mask();
        test_all_disabled();
        test_latency();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
